// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GET_HI,
    GET_LO,
    GET_CHK
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam logic [7:0] CHK_TARGET  = 8'hFF;

endpackage

// File: rtl/uart_cmd_frame.sv
// Parses HDR,hi,lo,chk byte frames from a UART receiver into 16-bit commands,
// flagging checksum, inter-byte timeout and overwrite errors.
module uart_cmd_frame
  import uart_cmd_pkg::*;
#(
  parameter logic [19:0] TMO_CYCLES = 20'd1_000_000,
  parameter logic [7:0]  HDR        = HDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        chk_err,
  output logic        tmo_err,
  output logic        ovr_err
);

  state_t      state, state_nxt;
  logic [7:0]  hi, lo;
  logic [19:0] tmo_cnt;
  logic [7:0]  sum;
  logic        tmo_hit;
  logic        frame_done;
  logic        cmd_load;

  // Every byte is consumed in the cycle it appears, regardless of state or reset.
  assign clr_rx_rdy = rx_rdy;

  assign sum        = hi + lo + rx_data;
  // A byte arriving in the saturation cycle takes priority over the timeout.
  assign tmo_hit    = (state != IDLE) && !rx_rdy && (tmo_cnt == TMO_CYCLES);
  assign frame_done = (state == GET_CHK) && rx_rdy;
  assign cmd_load   = frame_done && (sum == CHK_TARGET);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_rdy && rx_data == HDR) state_nxt = GET_HI;
      GET_HI:  if (rx_rdy) state_nxt = GET_LO;
               else if (tmo_hit) state_nxt = IDLE;
      GET_LO:  if (rx_rdy) state_nxt = GET_CHK;
               else if (tmo_hit) state_nxt = IDLE;
      GET_CHK: if (rx_rdy || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 8'h00;
      lo <= 8'h00;
    end else if (tmo_hit) begin
      hi <= 8'h00;
      lo <= 8'h00;
    end else if (rx_rdy) begin
      if (state == GET_HI) hi <= rx_data;
      if (state == GET_LO) lo <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 20'd0;
    end else if (state == IDLE || rx_rdy || tmo_hit) begin
      tmo_cnt <= 20'd0;
    end else if (tmo_cnt < TMO_CYCLES) begin
      tmo_cnt <= tmo_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= 16'h0000;
      cmd_rdy <= 1'b0;
    end else if (cmd_load) begin
      cmd     <= {hi, lo};
      cmd_rdy <= 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
      tmo_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      chk_err <= frame_done && !cmd_load;
      tmo_err <= tmo_hit;
      ovr_err <= cmd_load && cmd_rdy && !clr_cmd_rdy;
    end
  end

endmodule
